// File: rtl/jtag_bridge_pkg.sv
// Shared constants and FSM encoding for the JTAG UART word bridge.
package jtag_bridge_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_DATA = 2'd1,
    S_RD_CTRL = 2'd2,
    S_WR_CHAR = 2'd3
  } state_t;

  // Avalon register map of the JTAG UART core.
  localparam logic DATA_REG = 1'b0;
  localparam logic CTRL_REG = 1'b1;

  // Data register: RVALID flag; control register: WSPACE field.
  localparam int RVALID_BIT = 15;
  localparam int WSPACE_HI  = 31;
  localparam int WSPACE_LO  = 16;

endpackage

// File: rtl/jtag_word_bridge_if.sv
// Avalon-MM master port toward the JTAG UART core.
interface jtag_word_bridge_if;
  logic        av_address_o;
  logic        av_chipselect_o;
  logic        av_read_o;
  logic        av_write_o;
  logic [31:0] av_writedata_o;
  logic [31:0] av_readdata_i;
  logic        av_waitrequest_i;

  modport master (
    output av_address_o, av_chipselect_o, av_read_o, av_write_o, av_writedata_o,
    input  av_readdata_i, av_waitrequest_i
  );

  modport slave (
    input  av_address_o, av_chipselect_o, av_read_o, av_write_o, av_writedata_o,
    output av_readdata_i, av_waitrequest_i
  );
endinterface

// File: rtl/word_fifo.sv
// Synchronous show-ahead 32-bit FIFO with registered full/empty flags.
module word_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     push,
  input  logic [31:0]              push_data,
  input  logic                     pop,
  output logic [31:0]              head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q;
  logic          push_ok, pop_ok;

  // Pop needs data; push needs room, or a same-cycle pop freeing a slot.
  assign pop_ok  = pop && !empty_q;
  assign push_ok = push && (!full_q || pop_ok);
  assign count_d = count_q + CW'(push_ok) - CW'(pop_ok);

  // Storage array, no reset so it can map to RAM.
  always_ff @(posedge clock_i) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers, occupancy and registered flags.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == FULL_CNT);
      empty_q <= (count_d == '0);
    end
  end

  // Head reads as zero while empty so stale RAM never leaks out.
  assign head  = empty_q ? '0 : mem[rd_ptr];
  assign count = count_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/jtag_word_bridge.sv
// Packs UART RX characters into 32-bit words and unpacks TX words into
// characters, little-endian, by polling the JTAG UART over Avalon-MM.
module jtag_word_bridge
  import jtag_bridge_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic               clock_i,
  input  logic               reset_i,
  jtag_word_bridge_if.master av,
  output logic               rx_empty_o,
  output logic [31:0]        rx_data_o,
  input  logic               rx_read_i,
  output logic               tx_full_o,
  input  logic               tx_write_i,
  input  logic [31:0]        tx_data_i,
  output logic               overflow_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  state_t        state_q, state_d;
  logic [1:0]    rx_idx_q, rx_idx_d;
  logic [1:0]    tx_idx_q, tx_idx_d;
  logic [2:0]    credit_q, credit_d;
  logic          rr_q, rr_d;
  logic [23:0]   rx_word_q, rx_word_d;
  logic          rx_push, tx_pop;
  logic [31:0]   rx_push_data, tx_head;
  logic [CW-1:0] rx_count, tx_count_unused;
  logic          rx_full_unused, tx_empty;
  logic          rx_ok, tx_ok;
  logic [2:0]    room;
  logic [15:0]   wspace;
  logic [7:0]    rd_char;
  logic          overflow_q;
  logic          unused_rd;

  assign unused_rd = ^av.av_readdata_i[14:8];

  word_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .push      (rx_push),
    .push_data (rx_push_data),
    .pop       (rx_read_i),
    .head      (rx_data_o),
    .count     (rx_count),
    .full      (rx_full_unused),
    .empty     (rx_empty_o)
  );

  word_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .push      (tx_write_i),
    .push_data (tx_data_i),
    .pop       (tx_pop),
    .head      (tx_head),
    .count     (tx_count_unused),
    .full      (tx_full_o),
    .empty     (tx_empty)
  );

  // RX may only be polled while a full slot is guaranteed for the word in
  // progress: a data-register read consumes the character irrecoverably.
  assign rx_ok   = rx_count < DEPTH_CNT;
  assign tx_ok   = !tx_empty;
  assign room    = 3'd4 - {1'b0, tx_idx_q};
  assign wspace  = av.av_readdata_i[WSPACE_HI:WSPACE_LO];
  assign rd_char = av.av_readdata_i[7:0];

  // Next-state, lane packing/unpacking and FIFO strobes.
  always_comb begin
    state_d      = state_q;
    rx_idx_d     = rx_idx_q;
    tx_idx_d     = tx_idx_q;
    credit_d     = credit_q;
    rr_d         = rr_q;
    rx_word_d    = rx_word_q;
    rx_push      = 1'b0;
    rx_push_data = {rd_char, rx_word_q};
    tx_pop       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rx_ok && tx_ok) state_d = rr_q ? S_RD_CTRL : S_RD_DATA;
        else if (rx_ok)     state_d = S_RD_DATA;
        else if (tx_ok)     state_d = S_RD_CTRL;
      end
      S_RD_DATA: begin
        if (!av.av_waitrequest_i) begin
          state_d = S_IDLE;
          rr_d    = ~rr_q;
          if (av.av_readdata_i[RVALID_BIT]) begin
            rx_idx_d = rx_idx_q + 2'd1;
            unique case (rx_idx_q)
              2'd0:    rx_word_d[7:0]   = rd_char;
              2'd1:    rx_word_d[15:8]  = rd_char;
              2'd2:    rx_word_d[23:16] = rd_char;
              default: rx_push          = 1'b1;
            endcase
          end
        end
      end
      S_RD_CTRL: begin
        if (!av.av_waitrequest_i) begin
          credit_d = (wspace < {13'd0, room}) ? wspace[2:0] : room;
          if (credit_d != 3'd0) begin
            state_d = S_WR_CHAR;
          end else begin
            state_d = S_IDLE;
            rr_d    = ~rr_q;
          end
        end
      end
      S_WR_CHAR: begin
        if (!av.av_waitrequest_i) begin
          credit_d = credit_q - 3'd1;
          tx_idx_d = tx_idx_q + 2'd1;
          tx_pop   = (tx_idx_q == 2'd3);
          if (credit_d == 3'd0) begin
            state_d = S_IDLE;
            rr_d    = ~rr_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and word-assembly registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      rx_idx_q  <= '0;
      tx_idx_q  <= '0;
      credit_q  <= '0;
      rr_q      <= 1'b0;
      rx_word_q <= '0;
    end else begin
      state_q   <= state_d;
      rx_idx_q  <= rx_idx_d;
      tx_idx_q  <= tx_idx_d;
      credit_q  <= credit_d;
      rr_q      <= rr_d;
      rx_word_q <= rx_word_d;
    end
  end

  // Avalon outputs are registered from the next state, so they rise with
  // the access state, hold through waitrequest and drop the cycle after.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      av.av_address_o    <= DATA_REG;
      av.av_chipselect_o <= 1'b0;
      av.av_read_o       <= 1'b0;
      av.av_write_o      <= 1'b0;
      av.av_writedata_o  <= '0;
    end else begin
      av.av_address_o    <= (state_d == S_RD_CTRL) ? CTRL_REG : DATA_REG;
      av.av_chipselect_o <= (state_d != S_IDLE);
      av.av_read_o       <= (state_d == S_RD_DATA) || (state_d == S_RD_CTRL);
      av.av_write_o      <= (state_d == S_WR_CHAR);
      av.av_writedata_o  <= (state_d == S_WR_CHAR) ?
                            {24'd0, tx_head[{tx_idx_d, 3'b000} +: 8]} : 32'd0;
    end
  end

  // Sticky flag for TX words dropped because the FIFO had no room.
  always_ff @(posedge clock_i) begin
    if (reset_i) overflow_q <= 1'b0;
    else if (tx_write_i && tx_full_o && !tx_pop) overflow_q <= 1'b1;
  end

  assign overflow_o = overflow_q;

endmodule

// File: doc/jtag_word_bridge.md
# jtag_word_bridge

Upstream stage of the JTAG communication controller: translates between the 8-bit character stream of the Avalon-MM JTAG UART core and the 32-bit word FIFO interface the controller consumes. It polls the UART, packs four received characters into one RX word, and unpacks queued TX words into four characters. Byte order is fixed little-endian (byte 0 = bits [7:0], sent and received first); the host script matches this.

## Interface
- DEPTH, 16: words per RX and TX FIFO; power of two, at least 2.
- clock_i  in  1  system clock.
- reset_i  in  1  synchronous, active-high reset.
- av_address_o  out  1  0 = data register, 1 = control register.
- av_chipselect_o  out  1  access strobe.
- av_read_o  out  1  read request.
- av_write_o  out  1  write request.
- av_writedata_o  out  32  {24'b0, char}.
- av_readdata_i  in  32  data register: [15] RVALID, [7:0] char. Control register: [31:16] WSPACE.
- av_waitrequest_i  in  1  stall; transfer completes in the first cycle it is low.
- rx_empty_o  out  1  RX FIFO empty.
- rx_data_o  out  32  RX head word, show-ahead; valid whenever !rx_empty_o.
- rx_read_i  in  1  pop RX head.
- tx_full_o  out  1  TX FIFO full.
- tx_write_i  in  1  push tx_data_i.
- tx_data_i  in  32  word to transmit.
- overflow_o  out  1  sticky: a TX push was attempted while full.

## Operation
- **States:**
  - S_IDLE: choose the next UART access.
  - S_RD_DATA: read address 0.
  - S_RD_CTRL: read address 1.
  - S_WR_CHAR: write address 0.
- **Arbitration in S_IDLE:**
  - rx_ok = RX count < DEPTH. The in-progress word therefore always has a slot, because reading the data register pops the character irrecoverably.
  - tx_ok = TX FIFO non-empty.
  - If both are true, a round-robin bit picks; it flips after each completed visit.
  - If only one is true, that side is taken. If neither is true, stay in S_IDLE.
- **S_RD_DATA:**
  - Hold the strobes while av_waitrequest_i is high.
  - On completion with RVALID = 1: write the char into byte lane rx_idx, then increment rx_idx (2-bit). On wrap 3→0, push the assembled word into the RX FIFO.
  - With RVALID = 0, nothing changes.
  - Always return to S_IDLE.
- **S_RD_CTRL:**
  - On completion, load credit = min(WSPACE, 4 − tx_idx).
  - Go to S_WR_CHAR if credit ≠ 0, else S_IDLE.
- **S_WR_CHAR:**
  - av_writedata_o = lane tx_idx of the TX head word.
  - On completion: credit−1 and tx_idx+1. On tx_idx wrap 3→0, pop the TX FIFO.
  - Stay while credit ≠ 0, else go to S_IDLE.
- **FIFO rules:**
  - A simultaneous push and pop leaves the count unchanged; on a full FIFO, push and pop in the same cycle is legal.
  - rx_read_i while empty is ignored.
  - tx_write_i while full drops the word and sets overflow_o (cleared only by reset).
- **Reset, including mid-transfer:**
  - FIFOs, rx_idx, tx_idx, credit and round-robin bit go to 0; FSM goes to S_IDLE.
  - A partially assembled or partially sent word is discarded. The controller's purge/sync sequence recovers the host.

## Timing
- Reset values: all av_* outputs 0, rx_empty_o = 1, rx_data_o = 0, tx_full_o = 0, overflow_o = 0.
- Avalon strobes and av_address_o are registered and asserted from the first cycle of S_RD_*/S_WR_CHAR. They stay stable until the cycle av_waitrequest_i is low, and deassert the next cycle.
- With zero wait states:
  - An RX visit is 2 cycles (access, idle). Character 4 of a word is visible on rx_data_o with rx_empty_o = 0 in the cycle after its completing access.
  - A full TX word is 1 (idle) + 1 (ctrl) + 4 (chars) = 6 cycles.
- tx_full_o and rx_empty_o are registered flags derived from the count; they update the cycle after the push/pop.
- Count width is log2(DEPTH)+1; pointers are log2(DEPTH) and wrap naturally.

## Structure
- Package jtag_bridge_pkg holds:
  - state encoding;
  - register addresses DATA_REG = 0, CTRL_REG = 1;
  - RVALID_BIT = 15;
  - WSPACE field [31:16].
- Sub-module word_fifo (synchronous, show-ahead, 32-bit, DEPTH entries, count/full/empty), instantiated for RX and TX.
- Packing, unpacking and the FSM stay in the top module.

## Test plan
- **RX packing:** UART model returns chars F2, B9, 78, 4A with RVALID = 1 → exactly one RX word 32'h4A78B9F2 and rx_empty_o falls once; any RVALID = 0 reads in between leave rx_idx unchanged.
- **TX unpacking:** push 32'hCD0031F7 with WSPACE = 64 → writes F7, 31, 00, CD in order, then the TX FIFO is empty.
- **Backpressure:** WSPACE = 2, then 0, then 64 → 2 chars written; the remaining 2 are written only after WSPACE recovers; no duplicated or skipped lane.
- **Full/overflow:** fill the RX FIFO with 16 words → no further data-register reads occur. Push 17 TX words with the UART stalled → overflow_o = 1 and the 17th word is lost.
- **Wait states and arbitration:** av_waitrequest_i high for 3 cycles during a write → strobes and data held stable. Both sides continuously busy → RX and TX visits alternate.
- **Reset mid-word:** assert reset_i after 2 RX chars → all outputs at reset values next cycle. The next 4 chars form a fresh word with no stale bytes.
